// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit memory between fetch and data.
// Accesses are serialised by a req/done handshake padded with wait states.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [15:0]           if_rdata,
    output logic                  if_done,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [15:0]           d_rdata,
    output logic                  d_done,
    output logic                  err_unaligned,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [3:0]            count;
    logic                  grant_d;
    logic                  last_grant_d;
    logic                  pick_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [15:0]           wdata_q;
    logic                  start;
    logic                  finish;

    // Round-robin pick: D wins alone, or on a tie when IF was granted last.
    always_comb begin
        pick_d = d_req && (!if_req || !last_grant_d);
    end

    // Next-state and memory-control decode.
    always_comb begin
        state_next = state;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        busy       = 1'b0;
        start      = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                if (count == 4'd0) begin
                    mem_wr     = wr_q;
                    finish     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            mem_enable = 1'b0;
            mem_wr     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant bookkeeping and latched request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_d      <= 1'b0;
            last_grant_d <= 1'b0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= 16'h0;
        end else if (start) begin
            grant_d      <= pick_d;
            last_grant_d <= pick_d;
            addr_q       <= pick_d ? d_addr : if_addr;
            wr_q         <= pick_d && d_wr;
            wdata_q      <= pick_d ? d_wdata : 16'h0;
        end
    end

    // Wait-state counter: loaded on grant, counts down while BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (start) begin
            count <= CNT_LOAD;
        end else if (state == BUSY && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // Completion pulses and read-data capture for the granted port.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_done       <= 1'b0;
            d_done        <= 1'b0;
            err_unaligned <= 1'b0;
            if_rdata      <= 16'h0;
            d_rdata       <= 16'h0;
        end else begin
            if_done       <= 1'b0;
            d_done        <= 1'b0;
            err_unaligned <= 1'b0;
            if (finish) begin
                err_unaligned <= addr_q[0];
                if (grant_d) begin
                    d_done <= 1'b1;
                    if (!wr_q) begin
                        d_rdata <= mem_rdata;
                    end
                end else begin
                    if_done  <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

    // Memory address and data always come from the latched request.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural memory.
// Instance a uses WAIT_CYCLES=3, instance b uses WAIT_CYCLES=1.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    logic        a_if_req, a_d_req, a_d_wr;
    logic [15:0] a_if_addr, a_d_addr, a_d_wdata;
    logic [15:0] a_if_rdata, a_d_rdata;
    logic        a_if_done, a_d_done, a_err, a_busy;
    logic        a_mem_enable, a_mem_wr;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_if_req, b_d_req, b_d_wr;
    logic [15:0] b_if_addr, b_d_addr, b_d_wdata;
    logic [15:0] b_if_rdata, b_d_rdata;
    logic        b_if_done, b_d_done, b_err, b_busy;
    logic        b_mem_enable, b_mem_wr;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [15:0] mem_a [0:32767];
    logic [15:0] mem_b [0:32767];
    logic        pl_a, pl_b;
    logic [14:0] pl_idx;
    logic [15:0] pl_data;

    int n_checks;
    int n_fail;

    mem_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(3)) u_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr),
        .if_rdata(a_if_rdata), .if_done(a_if_done),
        .d_req(a_d_req), .d_wr(a_d_wr), .d_addr(a_d_addr),
        .d_wdata(a_d_wdata), .d_rdata(a_d_rdata), .d_done(a_d_done),
        .err_unaligned(a_err), .busy(a_busy),
        .mem_enable(a_mem_enable), .mem_wr(a_mem_wr),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(1)) u_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr),
        .if_rdata(b_if_rdata), .if_done(b_if_done),
        .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_done(b_d_done),
        .err_unaligned(b_err), .busy(b_busy),
        .mem_enable(b_mem_enable), .mem_wr(b_mem_wr),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory a: combinational read, write on the clock edge.
    always_comb begin
        a_mem_rdata = (a_mem_enable && !a_mem_wr) ? mem_a[a_mem_addr[15:1]] : 16'h0;
    end
    always @(posedge clk) begin
        if (pl_a) mem_a[pl_idx] <= pl_data;
        else if (a_mem_enable && a_mem_wr) mem_a[a_mem_addr[15:1]] <= a_mem_wdata;
    end

    // Memory b.
    always_comb begin
        b_mem_rdata = (b_mem_enable && !b_mem_wr) ? mem_b[b_mem_addr[15:1]] : 16'h0;
    end
    always @(posedge clk) begin
        if (pl_b) mem_b[pl_idx] <= pl_data;
        else if (b_mem_enable && b_mem_wr) mem_b[b_mem_addr[15:1]] <= b_mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit sel, input logic [14:0] idx, input logic [15:0] data);
        pl_idx  = idx;
        pl_data = data;
        if (sel) pl_b = 1'b1;
        else pl_a = 1'b1;
        step();
        pl_a = 1'b0;
        pl_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_if_done !== 1'b0) begin n_fail++; $display("FAIL reset_if_done: got %b want 0", a_if_done); end
        n_checks++; if (a_d_done !== 1'b0) begin n_fail++; $display("FAIL reset_d_done: got %b want 0", a_d_done); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", a_err); end
        n_checks++; if (a_mem_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mem_enable: got %b want 0", a_mem_enable); end
        n_checks++; if (a_mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", a_mem_wr); end
        n_checks++; if (a_if_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h want 0000", a_if_rdata); end
        n_checks++; if (a_d_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 0000", a_d_rdata); end
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
        n_checks++; if (b_mem_enable !== 1'b0) begin n_fail++; $display("FAIL reset_b_mem_enable: got %b want 0", b_mem_enable); end
        rst = 1'b0;
    endtask

    task automatic test_if_read();
        preload(1'b0, 15'h0008, 16'hA5A5);
        a_if_addr = 16'h0010;
        a_if_req  = 1'b1;
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL ifrd_c0_busy: got %b want 0", a_busy); end
        for (int c = 1; c <= 3; c++) begin
            step();
            n_checks++; if (a_mem_enable !== 1'b1) begin n_fail++; $display("FAIL ifrd_c%0d_enable: got %b want 1", c, a_mem_enable); end
            n_checks++; if (a_if_done !== 1'b0) begin n_fail++; $display("FAIL ifrd_c%0d_done: got %b want 0", c, a_if_done); end
        end
        step();
        n_checks++; if (a_if_done !== 1'b1) begin n_fail++; $display("FAIL ifrd_c4_done: got %b want 1", a_if_done); end
        n_checks++; if (a_if_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL ifrd_rdata: got %h want a5a5", a_if_rdata); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL ifrd_err: got %b want 0", a_err); end
        n_checks++; if (a_mem_enable !== 1'b0) begin n_fail++; $display("FAIL ifrd_c4_enable: got %b want 0", a_mem_enable); end
        a_if_req = 1'b0;
        step();
        n_checks++; if (a_if_done !== 1'b0) begin n_fail++; $display("FAIL ifrd_c5_done: got %b want 0", a_if_done); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL ifrd_c5_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_d_write_read();
        a_d_req   = 1'b1;
        a_d_wr    = 1'b1;
        a_d_addr  = 16'h0020;
        a_d_wdata = 16'h1234;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++; if (a_mem_wr !== (c == 3)) begin n_fail++; $display("FAIL dwr_c%0d_mem_wr: got %b want %b", c, a_mem_wr, (c == 3)); end
            if (c == 2) a_d_wdata = 16'hDEAD;
            if (c == 3) begin
                n_checks++; if (a_mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL dwr_latched_wdata: got %h want 1234", a_mem_wdata); end
                n_checks++; if (a_mem_addr !== 16'h0020) begin n_fail++; $display("FAIL dwr_mem_addr: got %h want 0020", a_mem_addr); end
            end
            n_checks++; if (a_d_done !== (c == 4)) begin n_fail++; $display("FAIL dwr_c%0d_done: got %b want %b", c, a_d_done, (c == 4)); end
        end
        a_d_req   = 1'b0;
        a_d_wdata = 16'h1234;
        step();
        n_checks++; if (mem_a[15'h0010] !== 16'h1234) begin n_fail++; $display("FAIL dwr_mem_content: got %h want 1234", mem_a[15'h0010]); end
        a_d_req = 1'b1;
        a_d_wr  = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            n_checks++; if (a_mem_wr !== 1'b0) begin n_fail++; $display("FAIL drd_c%0d_mem_wr: got %b want 0", c, a_mem_wr); end
        end
        step();
        n_checks++; if (a_d_done !== 1'b1) begin n_fail++; $display("FAIL drd_done: got %b want 1", a_d_done); end
        n_checks++; if (a_d_rdata !== 16'h1234) begin n_fail++; $display("FAIL drd_rdata: got %h want 1234", a_d_rdata); end
        n_checks++; if (a_if_done !== 1'b0) begin n_fail++; $display("FAIL drd_if_done: got %b want 0", a_if_done); end
        n_checks++; if (a_if_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL drd_if_rdata_kept: got %h want a5a5", a_if_rdata); end
        a_d_req = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        a_if_addr = 16'h0010;
        a_d_addr  = 16'h0020;
        a_d_wr    = 1'b0;
        a_if_req  = 1'b1;
        a_d_req   = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= 3; c++) begin
                step();
                n_checks++; if ({a_if_done, a_d_done} !== 2'b00) begin n_fail++; $display("FAIL rr_g%0d_c%0d_done: got %b want 00", k, c, {a_if_done, a_d_done}); end
            end
            step();
            if (k % 2 == 0) begin
                n_checks++; if ({a_if_done, a_d_done} !== 2'b01) begin n_fail++; $display("FAIL rr_g%0d_winner: got if/d %b want 01", k, {a_if_done, a_d_done}); end
                n_checks++; if (a_d_rdata !== 16'h1234) begin n_fail++; $display("FAIL rr_g%0d_d_rdata: got %h want 1234", k, a_d_rdata); end
            end else begin
                n_checks++; if ({a_if_done, a_d_done} !== 2'b10) begin n_fail++; $display("FAIL rr_g%0d_winner: got if/d %b want 10", k, {a_if_done, a_d_done}); end
                n_checks++; if (a_if_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL rr_g%0d_if_rdata: got %h want a5a5", k, a_if_rdata); end
            end
            if (k == 3) begin
                a_if_req = 1'b0;
                a_d_req  = 1'b0;
            end
            step();
            n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rr_g%0d_idle: got busy %b want 0", k, a_busy); end
        end
    endtask

    task automatic test_reset_mid_write();
        preload(1'b0, 15'h0020, 16'h5555);
        a_d_req   = 1'b1;
        a_d_wr    = 1'b1;
        a_d_addr  = 16'h0040;
        a_d_wdata = 16'hBEEF;
        step();
        n_checks++; if (a_mem_wr !== 1'b0) begin n_fail++; $display("FAIL rstw_c1_mem_wr: got %b want 0", a_mem_wr); end
        n_checks++; if (a_mem_enable !== 1'b1) begin n_fail++; $display("FAIL rstw_c1_enable: got %b want 1", a_mem_enable); end
        step();
        rst = 1'b1;
        n_checks++; if (a_mem_wr !== 1'b0) begin n_fail++; $display("FAIL rstw_c2_mem_wr: got %b want 0", a_mem_wr); end
        step();
        rst     = 1'b0;
        a_d_req = 1'b0;
        a_d_wr  = 1'b0;
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rstw_idle: got busy %b want 0", a_busy); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if ({a_d_done, a_mem_wr} !== 2'b00) begin n_fail++; $display("FAIL rstw_post%0d done/wr: got %b want 00", c, {a_d_done, a_mem_wr}); end
            step();
        end
        n_checks++; if (mem_a[15'h0020] !== 16'h5555) begin n_fail++; $display("FAIL rstw_mem_kept: got %h want 5555", mem_a[15'h0020]); end
    endtask

    task automatic test_unaligned();
        preload(1'b0, 15'h0018, 16'h7777);
        a_d_req  = 1'b1;
        a_d_wr   = 1'b0;
        a_d_addr = 16'h0031;
        step();
        step();
        step();
        n_checks++; if (a_mem_addr !== 16'h0031) begin n_fail++; $display("FAIL unal_mem_addr: got %h want 0031", a_mem_addr); end
        step();
        n_checks++; if (a_d_done !== 1'b1) begin n_fail++; $display("FAIL unal_done: got %b want 1", a_d_done); end
        n_checks++; if (a_d_rdata !== 16'h7777) begin n_fail++; $display("FAIL unal_rdata: got %h want 7777", a_d_rdata); end
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL unal_err: got %b want 1", a_err); end
        a_d_req = 1'b0;
        step();
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL unal_err_clear: got %b want 0", a_err); end
    endtask

    task automatic test_back_to_back();
        bit exp_busy [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bit exp_done [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        preload(1'b1, 15'h0000, 16'h1111);
        preload(1'b1, 15'h0001, 16'h2222);
        b_if_addr = 16'h0000;
        b_if_req  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) step();
            n_checks++; if (b_busy !== exp_busy[c]) begin n_fail++; $display("FAIL b2b_c%0d_busy: got %b want %b", c, b_busy, exp_busy[c]); end
            n_checks++; if (b_if_done !== exp_done[c]) begin n_fail++; $display("FAIL b2b_c%0d_done: got %b want %b", c, b_if_done, exp_done[c]); end
            if (c == 2) begin
                n_checks++; if (b_if_rdata !== 16'h1111) begin n_fail++; $display("FAIL b2b_rdata0: got %h want 1111", b_if_rdata); end
                b_if_addr = 16'h0002;
            end
            if (c == 5) begin
                n_checks++; if (b_if_rdata !== 16'h2222) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 2222", b_if_rdata); end
                b_if_req = 1'b0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        pl_a      = 1'b0;
        pl_b      = 1'b0;
        pl_idx    = 15'h0;
        pl_data   = 16'h0;
        a_if_req  = 1'b0;
        a_if_addr = 16'h0;
        a_d_req   = 1'b0;
        a_d_wr    = 1'b0;
        a_d_addr  = 16'h0;
        a_d_wdata = 16'h0;
        b_if_req  = 1'b0;
        b_if_addr = 16'h0;
        b_d_req   = 1'b0;
        b_d_wr    = 1'b0;
        b_d_addr  = 16'h0;
        b_d_wdata = 16'h0;
        test_reset();
        test_if_read();
        test_d_write_read();
        test_round_robin();
        test_reset_mid_write();
        test_unaligned();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
